// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus interface shared by the host-side master and the register slave.
// The interface's own clk/rst_n are carried for completeness; the slave ignores them.
interface axi4lite_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst_n
);
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      arvalid;
  logic                      arready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;
  logic                      rvalid;
  logic                      rready;

  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  modport slave_mp (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid,    output wready,
    output bresp, bvalid,           input  bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid,    input  rready
  );

  modport master_mp (
    output awaddr, awprot, awvalid, input  awready,
    output wdata, wstrb, wvalid,    input  wready,
    input  bresp, bvalid,           output bready,
    output araddr, arprot, arvalid, input  arready,
    input  rdata, rresp, rvalid,    output rready
  );
endinterface

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank for the miner core: CTRL (start pulse), STATUS (read-only),
// and NUM_REGS-2 byte-enabled RW words exported on reg_q.
// Optional interrupt support is enabled by defining AXIL_REGS_IRQ_EN.
module axi4lite_reg_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  axi4lite_if.slave_mp                 s_axi,
  input  logic [31:0]                  status_i,
  input  logic                         done_i,
  output logic                         start_o,
  output logic                         irq_o,
  output logic [(NUM_REGS-2)*32-1:0]   reg_q
);
  localparam int unsigned IdxW = ADDR_WIDTH - 2;
  typedef logic [IdxW-1:0] idx_t;
  localparam idx_t NumRegsIdx = idx_t'(NUM_REGS);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  idx_t widx, ridx;
  logic wr_accept, rd_accept, ctrl_wr;

  logic [NUM_REGS-3:0][31:0] regs_q, regs_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;
  logic                      rvalid_q, rvalid_d;
  logic [1:0]                rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      start_q, start_d;
  logic [DATA_WIDTH-1:0]     ctrl_rd;

  assign widx = s_axi.awaddr[ADDR_WIDTH-1:2];
  assign ridx = s_axi.araddr[ADDR_WIDTH-1:2];

  // Address and data are only ever taken together; no new request while a response is pending.
  assign wr_accept     = ~rst & s_axi.awvalid & s_axi.wvalid & ~bvalid_q;
  assign rd_accept     = ~rst & s_axi.arvalid & ~rvalid_q;
  assign s_axi.awready = wr_accept;
  assign s_axi.wready  = wr_accept;
  assign s_axi.arready = rd_accept;
  assign ctrl_wr       = wr_accept & (widx == '0) & s_axi.wstrb[0];

  assign s_axi.bvalid = bvalid_q;
  assign s_axi.bresp  = bresp_q;
  assign s_axi.rvalid = rvalid_q;
  assign s_axi.rresp  = rresp_q;
  assign s_axi.rdata  = rdata_q;
  assign start_o      = start_q;
  assign reg_q        = regs_q;

`ifdef AXIL_REGS_IRQ_EN
  logic irq_en_q, irq_en_d, irq_pend_q, irq_pend_d, irq_q, irq_d;

  // IRQ_EN is sticky RW; IRQ_PEND is set by done_i and W1C, with set taking priority.
  always_comb begin
    irq_en_d   = irq_en_q;
    irq_pend_d = irq_pend_q;
    if (ctrl_wr) begin
      irq_en_d = s_axi.wdata[1];
      if (s_axi.wdata[2]) irq_pend_d = 1'b0;
    end
    if (done_i) irq_pend_d = 1'b1;
    irq_d = irq_pend_d & irq_en_d;
  end

  // Interrupt state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q   <= 1'b0;
      irq_pend_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      irq_en_q   <= irq_en_d;
      irq_pend_q <= irq_pend_d;
      irq_q      <= irq_d;
    end
  end

  assign irq_o   = irq_q;
  assign ctrl_rd = {{(DATA_WIDTH-3){1'b0}}, irq_pend_q, irq_en_q, 1'b0};
`else
  assign irq_o   = 1'b0;
  assign ctrl_rd = '0;
`endif

  logic unused_sigs;
  assign unused_sigs = ^{done_i, s_axi.awprot, s_axi.arprot,
                         s_axi.awaddr[1:0], s_axi.araddr[1:0]};

  // Write path: byte-enabled register update, B response and start pulse.
  always_comb begin
    regs_d   = regs_q;
    bvalid_d = bvalid_q;
    bresp_d  = bresp_q;
    start_d  = ctrl_wr & s_axi.wdata[0];
    if (bvalid_q && s_axi.bready) bvalid_d = 1'b0;
    if (wr_accept) begin
      bvalid_d = 1'b1;
      bresp_d  = (widx < NumRegsIdx) ? RespOkay : RespSlverr;
      for (int unsigned k = 2; k < NUM_REGS; k++) begin
        if (widx == idx_t'(k)) begin
          for (int unsigned b = 0; b < 4; b++) begin
            if (s_axi.wstrb[b]) regs_d[k-2][8*b +: 8] = s_axi.wdata[8*b +: 8];
          end
        end
      end
    end
  end

  // Read path: data is captured from current (pre-write) state at acceptance.
  always_comb begin
    rvalid_d = rvalid_q;
    rresp_d  = rresp_q;
    rdata_d  = rdata_q;
    if (rvalid_q && s_axi.rready) rvalid_d = 1'b0;
    if (rd_accept) begin
      rvalid_d = 1'b1;
      rresp_d  = (ridx < NumRegsIdx) ? RespOkay : RespSlverr;
      rdata_d  = '0;
      if (ridx == '0) begin
        rdata_d = ctrl_rd;
      end else if (ridx == idx_t'(1)) begin
        rdata_d = status_i;
      end else begin
        for (int unsigned k = 2; k < NUM_REGS; k++) begin
          if (ridx == idx_t'(k)) rdata_d = regs_q[k-2];
        end
      end
    end
  end

  // Bus-side state registers; reset discards any pending response.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q   <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= 2'b00;
      rvalid_q <= 1'b0;
      rresp_q  <= 2'b00;
      rdata_q  <= '0;
      start_q  <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      bvalid_q <= bvalid_d;
      bresp_q  <= bresp_d;
      rvalid_q <= rvalid_d;
      rresp_q  <= rresp_d;
      rdata_q  <= rdata_d;
      start_q  <= start_d;
    end
  end
endmodule
